exc_ctrl_seq: RTL and testbench
===============================

Name: exc_ctrl_seq

Overview:
Registered, parametrised exception/interrupt controller at the commit (MEM/WB) boundary of the MIPS pipeline. It synchronises and masks the hardware interrupt lines and resolves the committing instruction's exception flags by fixed priority. It emits one-cycle CP0 update strobes and a pipeline flush pulse. It holds a redirect PC toward fetch under a valid/ready handshake until fetch accepts it.

Parameters:
ADDR_W, 32, width of PC, EPC, BadVAddr and redirect address
N_HW_INT, 6, number of hardware interrupt lines (1..6)
SYNC_STAGES, 2, synchroniser flops per hardware interrupt line (>=2)
BOOT_BASE, 32'hBFC00200, exception base while boot_exp_vec=1

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous, active-low reset
commit_valid  in  1  commit-stage instruction valid this cycle
pc  in  ADDR_W  PC of committing instruction
in_delayslot  in  1  committing instruction is in a branch delay slot
invalid_inst, syscall, break_inst, eret, overflow  in  1 each  decoded exception flags
iaddr_err  in  1  fetch address error
daddr_err  in  1  data address error
daddr_we  in  1  data access was a store
mem_vaddr  in  ADDR_W  faulting data address
hw_int  in  N_HW_INT  asynchronous hardware interrupt lines
sw_int  in  2  Cause.IP[1:0]
int_mask  in  N_HW_INT+2  Status.IM
allow_int  in  1  Status {ERL,EXL,IE}==001
ebase  in  ADDR_W-12  EBase upper bits
epc_in  in  ADDR_W  current EPC
special_int_vec  in  1  Cause.IV
boot_exp_vec  in  1  Status.BEV
redirect_ready  in  1  fetch accepts redirect
flush  out  1  one-cycle pipeline flush
cp0_wr_exp  out  1  one-cycle exception commit strobe to CP0
cp0_clean_exl  out  1  one-cycle ERET strobe
cp0_badv_we  out  1  one-cycle BadVAddr write strobe
exp_code  out  5  ExcCode
exp_epc  out  ADDR_W  EPC to record
exp_bd  out  1  Cause.BD value
exp_bad_vaddr  out  ADDR_W  BadVAddr value
irq_pending  out  N_HW_INT+2  masked pending vector {hw_sync, sw_int} & int_mask, to Cause.IP
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  ADDR_W  redirect target
busy  out  1  controller not IDLE; commit must stall

Behaviour:
- Reset (resetn=0, async): all outputs 0, synchroniser flops 0, state IDLE. Reset mid-REDIRECT drops the request.
- hw_int passes through SYNC_STAGES flops; irq_pending is registered, latency SYNC_STAGES+1 cycles from the hw_int edge.
- base = boot_exp_vec ? BOOT_BASE : {ebase,12'b0}; general vector = base+0x180; interrupt vector = base+0x200 if special_int_vec, else base+0x180.
- Decision taken in IDLE only, when commit_valid=1. Priority:
  1. Int (allow_int & |irq_pending & ~invalid_inst), code 0x00.
  2. iaddr_err, code 0x04, BadVAddr=pc.
  3. invalid_inst, 0x0A.
  4. overflow, 0x0C.
  5. syscall, 0x08.
  6. break_inst, 0x09.
  7. daddr_err, daddr_we ? 0x05 : 0x04, BadVAddr=mem_vaddr.
  8. eret.
  9. none.
- Exception (1-7), at next edge: flush=1, cp0_wr_exp=1, cp0_badv_we as listed (1 cycle each); exp_code; exp_epc = in_delayslot ? pc-4 : pc (modulo 2^ADDR_W); exp_bd = in_delayslot; redirect_pc = vector; redirect_valid=1; state -> REDIRECT.
- ERET: flush=1, cp0_clean_exl=1, cp0_wr_exp=0, exp_code=0, redirect_pc=epc_in, state -> REDIRECT.
- None: no strobes, stay IDLE.
- REDIRECT: redirect_valid and redirect_pc held stable; busy=1; commit inputs ignored. When redirect_ready=1, state -> IDLE at that edge and redirect_valid=0 next cycle. redirect_ready high in the first REDIRECT cycle gives a single-cycle request.
- Strobes are never asserted for more than one cycle per event. Data outputs (exp_code, exp_epc, exp_bd, exp_bad_vaddr) hold their last values until the next event.
- Interrupt arriving while in REDIRECT stays pending and is taken on the next commit_valid cycle in IDLE.

Decomposition:
- Shared package exc_pkg: ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), vector offsets 0x180/0x200, state enum {IDLE, REDIRECT}.
- One sub-module, irq_sync: parametrised N-bit, SYNC_STAGES-deep synchroniser with async active-low reset.

Test Plan:
- hw_int[0] rises with int_mask=8'h04, allow_int=1, commit_valid=1, pc=0x80001000, BEV=0, ebase=0x80000 -> after 3 cycles irq_pending=0x04; next commit: flush 1 cycle, exp_code=0, exp_epc=0x80001000, redirect_pc=0x80000180.
- Same interrupt with special_int_vec=1 -> redirect_pc=0x80000200.
- syscall in delay slot, pc=0xBFC00384, BEV=1 -> exp_code=0x08, exp_epc=0xBFC00380, exp_bd=1, redirect_pc=0xBFC00380.
- daddr_err=1, daddr_we=1, mem_vaddr=0x80000003, overflow=1 simultaneously -> exp_code=0x0C, cp0_badv_we=0 (overflow outranks daddr_err).
- eret, epc_in=0x80002000, redirect_ready held 0 for 4 cycles -> cp0_clean_exl 1 cycle, redirect_valid held 4 cycles with pc stable; busy=1 throughout; returns to IDLE on the ready edge.
- resetn=0 asserted in REDIRECT -> redirect_valid and busy drop immediately (asynchronously); after release state IDLE.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the commit-stage exception controller: ExcCodes,
// vector offsets, controller states and the fixed-priority exception resolver.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [11:0] VEC_OFF_GEN = 12'h180;
  localparam logic [11:0] VEC_OFF_INT = 12'h200;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } exc_state_t;

  // Outcome of resolving one committing instruction's exception flags
  typedef struct packed {
    logic       take;          // an exception (not ERET) is raised
    logic [4:0] code;          // ExcCode to record
    logic       badv_we;       // BadVAddr must be written
    logic       badv_from_pc;  // BadVAddr source: 1 = pc, 0 = mem_vaddr
    logic       use_int_vec;   // redirect to the interrupt vector
  } exc_dec_t;

  // Fixed priority: Int > AdEL(fetch) > RI > Ov > Sys > Bp > data AdEL/AdES
  function automatic exc_dec_t exc_resolve(
    input logic int_take,
    input logic iaddr_err,
    input logic invalid_inst,
    input logic overflow,
    input logic syscall,
    input logic break_inst,
    input logic daddr_err,
    input logic daddr_we
  );
    exc_dec_t d;
    d      = '0;
    d.take = 1'b1;
    if (int_take) begin
      d.code        = EXC_INT;
      d.use_int_vec = 1'b1;
    end else if (iaddr_err) begin
      d.code         = EXC_ADEL;
      d.badv_we      = 1'b1;
      d.badv_from_pc = 1'b1;
    end else if (invalid_inst) begin
      d.code = EXC_RI;
    end else if (overflow) begin
      d.code = EXC_OV;
    end else if (syscall) begin
      d.code = EXC_SYS;
    end else if (break_inst) begin
      d.code = EXC_BP;
    end else if (daddr_err) begin
      d.code    = daddr_we ? EXC_ADES : EXC_ADEL;
      d.badv_we = 1'b1;
    end else begin
      d.take = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for asynchronous interrupt lines.
module irq_sync #(
  parameter int unsigned N      = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] i_async,
  output logic [N-1:0] o_sync
);

  logic [STAGES-1:0][N-1:0] r_sync;

  // Shift each line through STAGES flops; stage 0 samples the raw input
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/exc_ctrl_seq.sv
// Commit-stage exception/interrupt controller: resolves exceptions by fixed
// priority, pulses CP0 strobes and flush, and holds a fetch redirect until accepted.
module exc_ctrl_seq
  import exc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       N_HW_INT    = 6,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] BOOT_BASE   = 32'hBFC00200
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 commit_valid,
  input  logic [ADDR_W-1:0]    pc,
  input  logic                 in_delayslot,
  input  logic                 invalid_inst,
  input  logic                 syscall,
  input  logic                 break_inst,
  input  logic                 eret,
  input  logic                 overflow,
  input  logic                 iaddr_err,
  input  logic                 daddr_err,
  input  logic                 daddr_we,
  input  logic [ADDR_W-1:0]    mem_vaddr,
  input  logic [N_HW_INT-1:0]  hw_int,
  input  logic [1:0]           sw_int,
  input  logic [N_HW_INT+1:0]  int_mask,
  input  logic                 allow_int,
  input  logic [ADDR_W-13:0]   ebase,
  input  logic [ADDR_W-1:0]    epc_in,
  input  logic                 special_int_vec,
  input  logic                 boot_exp_vec,
  input  logic                 redirect_ready,
  output logic                 flush,
  output logic                 cp0_wr_exp,
  output logic                 cp0_clean_exl,
  output logic                 cp0_badv_we,
  output logic [4:0]           exp_code,
  output logic [ADDR_W-1:0]    exp_epc,
  output logic                 exp_bd,
  output logic [ADDR_W-1:0]    exp_bad_vaddr,
  output logic [N_HW_INT+1:0]  irq_pending,
  output logic                 redirect_valid,
  output logic [ADDR_W-1:0]    redirect_pc,
  output logic                 busy
);

  exc_state_t          r_state, w_state_nxt;
  logic                r_flush, w_flush_nxt;
  logic                r_wr_exp, w_wr_exp_nxt;
  logic                r_clean_exl, w_clean_exl_nxt;
  logic                r_badv_we, w_badv_we_nxt;
  logic [4:0]          r_exp_code, w_exp_code_nxt;
  logic [ADDR_W-1:0]   r_exp_epc, w_exp_epc_nxt;
  logic                r_exp_bd, w_exp_bd_nxt;
  logic [ADDR_W-1:0]   r_exp_bad_vaddr, w_exp_bad_vaddr_nxt;
  logic                r_redirect_valid, w_redirect_valid_nxt;
  logic [ADDR_W-1:0]   r_redirect_pc, w_redirect_pc_nxt;
  logic [N_HW_INT+1:0] r_irq_pending;

  logic [N_HW_INT-1:0] w_hw_sync;
  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W-1:0]   w_vec_gen;
  logic [ADDR_W-1:0]   w_vec_int;
  logic [ADDR_W-1:0]   w_epc_rec;
  logic                w_int_take;
  exc_dec_t            w_dec;

  irq_sync #(
    .N      (N_HW_INT),
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk     (clk),
    .resetn  (resetn),
    .i_async (hw_int),
    .o_sync  (w_hw_sync)
  );

  // Register the masked pending vector; this is also what the decision uses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq_pending <= '0;
    end else begin
      r_irq_pending <= {w_hw_sync, sw_int} & int_mask;
    end
  end

  // Vector targets, recorded EPC and prioritised exception for this commit
  always_comb begin
    w_base     = boot_exp_vec ? BOOT_BASE : {ebase, 12'h000};
    w_vec_gen  = w_base + ADDR_W'(VEC_OFF_GEN);
    w_vec_int  = special_int_vec ? (w_base + ADDR_W'(VEC_OFF_INT)) : w_vec_gen;
    w_epc_rec  = in_delayslot ? (pc - ADDR_W'(4)) : pc;
    w_int_take = allow_int & (|r_irq_pending) & ~invalid_inst;
    w_dec      = exc_resolve(w_int_take, iaddr_err, invalid_inst, overflow,
                             syscall, break_inst, daddr_err, daddr_we);
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= ST_IDLE;
      r_flush          <= 1'b0;
      r_wr_exp         <= 1'b0;
      r_clean_exl      <= 1'b0;
      r_badv_we        <= 1'b0;
      r_exp_code       <= '0;
      r_exp_epc        <= '0;
      r_exp_bd         <= 1'b0;
      r_exp_bad_vaddr  <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_flush          <= w_flush_nxt;
      r_wr_exp         <= w_wr_exp_nxt;
      r_clean_exl      <= w_clean_exl_nxt;
      r_badv_we        <= w_badv_we_nxt;
      r_exp_code       <= w_exp_code_nxt;
      r_exp_epc        <= w_exp_epc_nxt;
      r_exp_bd         <= w_exp_bd_nxt;
      r_exp_bad_vaddr  <= w_exp_bad_vaddr_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
    end
  end

  // Next state and next output values; strobes default low, data holds
  always_comb begin
    w_state_nxt          = r_state;
    w_flush_nxt          = 1'b0;
    w_wr_exp_nxt         = 1'b0;
    w_clean_exl_nxt      = 1'b0;
    w_badv_we_nxt        = 1'b0;
    w_exp_code_nxt       = r_exp_code;
    w_exp_epc_nxt        = r_exp_epc;
    w_exp_bd_nxt         = r_exp_bd;
    w_exp_bad_vaddr_nxt  = r_exp_bad_vaddr;
    w_redirect_valid_nxt = r_redirect_valid;
    w_redirect_pc_nxt    = r_redirect_pc;
    case (r_state)
      ST_IDLE: begin
        if (commit_valid) begin
          if (w_dec.take) begin
            w_state_nxt          = ST_REDIRECT;
            w_flush_nxt          = 1'b1;
            w_wr_exp_nxt         = 1'b1;
            w_badv_we_nxt        = w_dec.badv_we;
            w_exp_code_nxt       = w_dec.code;
            w_exp_epc_nxt        = w_epc_rec;
            w_exp_bd_nxt         = in_delayslot;
            if (w_dec.badv_we) begin
              w_exp_bad_vaddr_nxt = w_dec.badv_from_pc ? pc : mem_vaddr;
            end
            w_redirect_valid_nxt = 1'b1;
            w_redirect_pc_nxt    = w_dec.use_int_vec ? w_vec_int : w_vec_gen;
          end else if (eret) begin
            w_state_nxt          = ST_REDIRECT;
            w_flush_nxt          = 1'b1;
            w_clean_exl_nxt      = 1'b1;
            w_exp_code_nxt       = '0;
            w_redirect_valid_nxt = 1'b1;
            w_redirect_pc_nxt    = epc_in;
          end
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          w_state_nxt          = ST_IDLE;
          w_redirect_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt          = ST_IDLE;
        w_redirect_valid_nxt = 1'b0;
      end
    endcase
  end

  assign flush          = r_flush;
  assign cp0_wr_exp     = r_wr_exp;
  assign cp0_clean_exl  = r_clean_exl;
  assign cp0_badv_we    = r_badv_we;
  assign exp_code       = r_exp_code;
  assign exp_epc        = r_exp_epc;
  assign exp_bd         = r_exp_bd;
  assign exp_bad_vaddr  = r_exp_bad_vaddr;
  assign irq_pending    = r_irq_pending;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign busy           = (r_state == ST_REDIRECT);

endmodule

// File: tb/tb_exc_ctrl_seq.sv
// Directed bench for exc_ctrl_seq with a cycle-level reference model.
module tb_exc_ctrl_seq;

  localparam int AW = 32;
  localparam int NH = 6;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          commit_valid, in_delayslot, invalid_inst, syscall, break_inst;
  logic          eret, overflow, iaddr_err, daddr_err, daddr_we;
  logic [31:0]   pc, mem_vaddr, epc_in;
  logic [NH-1:0] hw_int;
  logic [1:0]    sw_int;
  logic [NH+1:0] int_mask;
  logic          allow_int, special_int_vec, boot_exp_vec, redirect_ready;
  logic [19:0]   ebase;

  logic          flush, cp0_wr_exp, cp0_clean_exl, cp0_badv_we, exp_bd;
  logic [4:0]    exp_code;
  logic [31:0]   exp_epc, exp_bad_vaddr, redirect_pc;
  logic [NH+1:0] irq_pending;
  logic          redirect_valid, busy;

  always #5 clk = ~clk;

  exc_ctrl_seq #(
    .ADDR_W      (AW),
    .N_HW_INT    (NH),
    .SYNC_STAGES (SS),
    .BOOT_BASE   (32'hBFC00200)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .commit_valid    (commit_valid),
    .pc              (pc),
    .in_delayslot    (in_delayslot),
    .invalid_inst    (invalid_inst),
    .syscall         (syscall),
    .break_inst      (break_inst),
    .eret            (eret),
    .overflow        (overflow),
    .iaddr_err       (iaddr_err),
    .daddr_err       (daddr_err),
    .daddr_we        (daddr_we),
    .mem_vaddr       (mem_vaddr),
    .hw_int          (hw_int),
    .sw_int          (sw_int),
    .int_mask        (int_mask),
    .allow_int       (allow_int),
    .ebase           (ebase),
    .epc_in          (epc_in),
    .special_int_vec (special_int_vec),
    .boot_exp_vec    (boot_exp_vec),
    .redirect_ready  (redirect_ready),
    .flush           (flush),
    .cp0_wr_exp      (cp0_wr_exp),
    .cp0_clean_exl   (cp0_clean_exl),
    .cp0_badv_we     (cp0_badv_we),
    .exp_code        (exp_code),
    .exp_epc         (exp_epc),
    .exp_bd          (exp_bd),
    .exp_bad_vaddr   (exp_bad_vaddr),
    .irq_pending     (irq_pending),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .busy            (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        take;
    logic        is_eret;
    logic [4:0]  code;
    logic        bwe;
    logic [31:0] badv;
    logic [31:0] vec;
  } dec_t;

  // Highest-priority raised cause wins; index order is the priority order
  function automatic dec_t decide(input logic [NH+1:0] pend);
    dec_t        d;
    logic [31:0] base;
    bit          cond [7];
    logic [4:0]  cd   [7];
    base = boot_exp_vec ? 32'hBFC00200 : {ebase, 12'h000};
    cond = '{allow_int && (pend != 0) && !invalid_inst, iaddr_err, invalid_inst,
             overflow, syscall, break_inst, daddr_err};
    cd   = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, daddr_we ? 5'h05 : 5'h04};
    d = '0;
    for (int i = 6; i >= 0; i--) begin
      if (cond[i]) begin
        d.take = 1'b1;
        d.code = cd[i];
        d.bwe  = (i == 1) || (i == 6);
        d.badv = (i == 1) ? pc : mem_vaddr;
        d.vec  = base + (((i == 0) && special_int_vec) ? 32'h200 : 32'h180);
      end
    end
    if (!d.take && eret) begin
      d.is_eret = 1'b1;
      d.vec     = epc_in;
    end
    return d;
  endfunction

  logic          m_flush, m_wr, m_clean, m_bwe, m_bd, m_rv, m_busy;
  logic [4:0]    m_code;
  logic [31:0]   m_epc, m_badv, m_rpc;
  logic [NH+1:0] m_pend;
  logic [NH-1:0] hw_log [0:4095];
  int            cyc;
  dec_t          m_dec;

  // hw_int value seen SS edges earlier (0 before that many edges since reset)
  function automatic logic [NH-1:0] hw_late(input int c);
    if (c >= SS) return hw_log[c-SS];
    return '0;
  endfunction

  always_comb m_dec = decide(m_pend);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc <= 0; m_pend <= '0;
      m_flush <= 1'b0; m_wr <= 1'b0; m_clean <= 1'b0; m_bwe <= 1'b0;
      m_code <= '0; m_epc <= '0; m_bd <= 1'b0; m_badv <= '0;
      m_rv <= 1'b0; m_rpc <= '0; m_busy <= 1'b0;
    end else begin
      hw_log[cyc] <= hw_int;
      cyc         <= cyc + 1;
      m_pend      <= {hw_late(cyc), sw_int} & int_mask;
      m_flush <= 1'b0; m_wr <= 1'b0; m_clean <= 1'b0; m_bwe <= 1'b0;
      if (m_busy) begin
        if (redirect_ready) begin
          m_busy <= 1'b0;
          m_rv   <= 1'b0;
        end
      end else if (commit_valid && m_dec.take) begin
        m_flush <= 1'b1; m_wr <= 1'b1; m_bwe <= m_dec.bwe;
        m_code  <= m_dec.code;
        m_epc   <= in_delayslot ? pc - 32'd4 : pc;
        m_bd    <= in_delayslot;
        if (m_dec.bwe) m_badv <= m_dec.badv;
        m_rpc <= m_dec.vec; m_rv <= 1'b1; m_busy <= 1'b1;
      end else if (commit_valid && m_dec.is_eret) begin
        m_flush <= 1'b1; m_clean <= 1'b1; m_code <= '0;
        m_rpc <= m_dec.vec; m_rv <= 1'b1; m_busy <= 1'b1;
      end
    end
  end

  // Every cycle, away from the active edge
  always @(negedge clk) begin
    chk("flush",          32'(flush),          32'(m_flush));
    chk("cp0_wr_exp",     32'(cp0_wr_exp),     32'(m_wr));
    chk("cp0_clean_exl",  32'(cp0_clean_exl),  32'(m_clean));
    chk("cp0_badv_we",    32'(cp0_badv_we),    32'(m_bwe));
    chk("exp_code",       32'(exp_code),       32'(m_code));
    chk("exp_epc",        exp_epc,             m_epc);
    chk("exp_bd",         32'(exp_bd),         32'(m_bd));
    chk("exp_bad_vaddr",  exp_bad_vaddr,       m_badv);
    chk("irq_pending",    32'(irq_pending),    32'(m_pend));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("redirect_pc",    redirect_pc,         m_rpc);
    chk("busy",           32'(busy),           32'(m_busy));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_flags();
    commit_valid = 0; in_delayslot = 0; invalid_inst = 0; syscall = 0;
    break_inst = 0; eret = 0; overflow = 0; iaddr_err = 0; daddr_err = 0; daddr_we = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clear_flags();
    pc = '0; mem_vaddr = '0; epc_in = '0; hw_int = '0; sw_int = '0; int_mask = '0;
    allow_int = 0; special_int_vec = 0; boot_exp_vec = 0; redirect_ready = 0; ebase = '0;
    tick(2);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rv",    32'(redirect_valid), 32'd0);
    chk("rst_pend",  32'(irq_pending), 32'd0);
    resetn = 1;

    // hardware interrupt, general vector
    ebase = 20'h80000; int_mask = 8'h04; allow_int = 1; pc = 32'h80001000;
    commit_valid = 1; hw_int = 6'b000001;
    tick(2);
    chk("int_pend_early", 32'(irq_pending), 32'h00);
    chk("int_noflush_early", 32'(flush), 32'd0);
    tick(1);
    chk("int_pend_lat3", 32'(irq_pending), 32'h04);
    chk("int_noflush", 32'(flush), 32'd0);
    tick(1);
    chk("int_flush",  32'(flush), 32'd1);
    chk("int_code",   32'(exp_code), 32'h00);
    chk("int_epc",    exp_epc, 32'h80001000);
    chk("int_rpc",    redirect_pc, 32'h80000180);
    chk("int_busy",   32'(busy), 32'd1);
    commit_valid = 0; redirect_ready = 1;
    tick(1);
    chk("int_flush_1cyc", 32'(flush), 32'd0);
    chk("int_ready_idle", 32'(busy), 32'd0);

    // same interrupt through the special vector
    special_int_vec = 1; commit_valid = 1; redirect_ready = 0;
    tick(1);
    chk("iv_rpc", redirect_pc, 32'h80000200);
    commit_valid = 0; hw_int = '0; allow_int = 0; special_int_vec = 0; redirect_ready = 1;
    tick(1);

    // syscall in a delay slot, boot vectors
    boot_exp_vec = 1; pc = 32'hBFC00384; in_delayslot = 1; syscall = 1;
    commit_valid = 1; redirect_ready = 0;
    tick(1);
    chk("sys_code", 32'(exp_code), 32'h08);
    chk("sys_epc",  exp_epc, 32'hBFC00380);
    chk("sys_bd",   32'(exp_bd), 32'd1);
    chk("sys_rpc",  redirect_pc, 32'hBFC00380);
    clear_flags(); redirect_ready = 1;
    tick(1);

    // overflow outranks data address error
    pc = 32'h80004000; overflow = 1; daddr_err = 1; daddr_we = 1;
    mem_vaddr = 32'h80000003; commit_valid = 1; redirect_ready = 0;
    tick(1);
    chk("ov_code",  32'(exp_code), 32'h0C);
    chk("ov_nobadv", 32'(cp0_badv_we), 32'd0);
    clear_flags(); redirect_ready = 1;
    tick(1);

    // store address error with ready already high: single-cycle request
    daddr_err = 1; daddr_we = 1; commit_valid = 1;
    tick(1);
    chk("ades_code", 32'(exp_code), 32'h05);
    chk("ades_bwe",  32'(cp0_badv_we), 32'd1);
    chk("ades_badv", exp_bad_vaddr, 32'h80000003);
    clear_flags();
    tick(1);
    chk("ades_rv_1cyc", 32'(redirect_valid), 32'd0);

    // fetch address error outranks syscall
    pc = 32'h80005001; iaddr_err = 1; syscall = 1; commit_valid = 1;
    tick(1);
    chk("adel_code", 32'(exp_code), 32'h04);
    chk("adel_badv", exp_bad_vaddr, 32'h80005001);
    clear_flags();
    tick(1);

    // pending software interrupt blocked by reserved instruction, then taken
    sw_int = 2'b01; int_mask = 8'h05; allow_int = 1; pc = 32'h80006000;
    tick(1);
    invalid_inst = 1; commit_valid = 1;
    tick(1);
    chk("ri_code", 32'(exp_code), 32'h0A);
    clear_flags();
    tick(1);
    commit_valid = 1;
    tick(1);
    chk("swi_code", 32'(exp_code), 32'h00);
    chk("swi_rpc",  redirect_pc, 32'hBFC00380);
    clear_flags(); sw_int = '0; allow_int = 0;
    tick(1);

    // ERET with a slow fetch
    epc_in = 32'h80002000; eret = 1; commit_valid = 1; redirect_ready = 0;
    tick(1);
    chk("eret_clean", 32'(cp0_clean_exl), 32'd1);
    chk("eret_nowr",  32'(cp0_wr_exp), 32'd0);
    chk("eret_rpc",   redirect_pc, 32'h80002000);
    clear_flags();
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("eret_hold_rv",    32'(redirect_valid), 32'd1);
      chk("eret_hold_busy",  32'(busy), 32'd1);
      chk("eret_hold_rpc",   redirect_pc, 32'h80002000);
      chk("eret_clean_1cyc", 32'(cp0_clean_exl), 32'd0);
    end
    redirect_ready = 1;
    tick(1);
    chk("eret_idle", 32'(busy), 32'd0);

    // asynchronous reset while redirecting
    syscall = 1; commit_valid = 1; redirect_ready = 0;
    tick(1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    clear_flags();
    #2 resetn = 0;
    #1;
    chk("arst_rv",   32'(redirect_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick(1);
    resetn = 1;
    tick(2);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
